// File: rtl/instr_fetch.sv
// Instruction fetch sequencer for the multicycle core.
// Walks a program counter through a synchronous program ROM. Each instruction
// word (and, for mvi, its trailing immediate word) is handed to the core on DIN
// with Run high, and the next fetch waits for the core's Done.
//
// Handshake: Run is a registered enable that is high only while the current
// word(s) are being executed. The core completes by pulsing Done, which is
// sampled on a rising edge only while Run is high. Done at any other time is
// ignored. Start is a level request that is sampled only in IDLE and HALT.
//
// A supervision counter limits how long an instruction may run without Done.
// Reaching the limit parks the block in ERROR until reset.
module instr_fetch #(
   parameter int               ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]       HALT_OP  = 4'hF,
   parameter logic [3:0]       MVI_OP   = 4'h1,
   parameter int               TIMEOUT  = 16
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [15:0]       DIN,
   output logic              Run,
   input  logic              Done,
   output logic [ADDR_W-1:0] pc,
   output logic              Halted,
   output logic              Error,
   output logic [2:0]        state_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_LATCH     = 3'd2,
      S_FETCH_IMM = 3'd3,
      S_LATCH_IMM = 3'd4,
      S_EXEC      = 3'd5,
      S_HALT      = 3'd6,
      S_ERROR     = 3'd7
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [15:0]       instr_q, instr_d;
   logic [15:0]       imm_q, imm_d;
   logic [15:0]       din_q, din_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              run_q, run_d;
   logic              halted_q, halted_d;
   logic              error_q, error_d;

   logic [CNT_W-1:0]  cnt_inc;
   logic              instr_is_mvi;

   assign cnt_inc      = cnt_q + 1'b1;
   assign instr_is_mvi = (instr_q[3:0] == MVI_OP);

   // Next-state, datapath updates and registered output values.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rom_addr_d = rom_addr_q;
      instr_d    = instr_q;
      imm_d      = imm_q;
      din_d      = din_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (Start) state_d = S_FETCH;
         end
         S_FETCH: begin
            rom_addr_d = pc_q;
            state_d    = S_LATCH;
         end
         S_LATCH: begin
            instr_d = rom_data;
            pc_d    = pc_q + 1'b1;
            if (rom_data[3:0] == HALT_OP) begin
               // DIN keeps showing the halt word while parked.
               din_d   = rom_data;
               state_d = S_HALT;
            end else if (rom_data[3:0] == MVI_OP) begin
               state_d = S_FETCH_IMM;
            end else begin
               din_d   = rom_data;
               state_d = S_EXEC;
            end
         end
         S_FETCH_IMM: begin
            rom_addr_d = pc_q;
            state_d    = S_LATCH_IMM;
         end
         S_LATCH_IMM: begin
            imm_d   = rom_data;
            pc_d    = pc_q + 1'b1;
            // The core captures the mvi word first; the immediate follows.
            din_d   = instr_q;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (Done) begin
               // Done beats a simultaneous timeout.
               cnt_d   = '0;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_inc;
               din_d = instr_is_mvi ? imm_q : instr_q;
               if (cnt_inc == TIMEOUT_C) state_d = S_ERROR;
            end
         end
         S_HALT: begin
            if (Start) state_d = S_FETCH;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      run_d    = (state_d == S_EXEC);
      halted_d = (state_d == S_HALT);
      error_d  = error_q | (state_d == S_ERROR);
   end

   // State and datapath registers; reset clears everything asynchronously.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         rom_addr_q <= RESET_PC;
         instr_q    <= '0;
         imm_q      <= '0;
         din_q      <= '0;
         cnt_q      <= '0;
         run_q      <= 1'b0;
         halted_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rom_addr_q <= rom_addr_d;
         instr_q    <= instr_d;
         imm_q      <= imm_d;
         din_q      <= din_d;
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         halted_q   <= halted_d;
         error_q    <= error_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign DIN      = din_q;
   assign Run      = run_q;
   assign pc       = pc_q;
   assign Halted   = halted_q;
   assign Error    = error_q;
   assign state_o  = state_q;

endmodule
